// File: rtl/cadr_seq_pkg.sv
// Shared phase definitions for the CADR4 microcycle sequencer and its consumers.
// State index constants name the bit positions of the one-hot state register.
package cadr_seq_pkg;

    localparam int NSTATES  = 7;

    localparam int S_DECODE = 0;
    localparam int S_READ   = 1;
    localparam int S_ALU    = 2;
    localparam int S_WRITE  = 3;
    localparam int S_MMU    = 4;
    localparam int S_FETCH  = 5;
    localparam int S_HALT   = 6;

    typedef enum logic [NSTATES-1:0] {
        ST_DECODE = NSTATES'(1) << S_DECODE,
        ST_READ   = NSTATES'(1) << S_READ,
        ST_ALU    = NSTATES'(1) << S_ALU,
        ST_WRITE  = NSTATES'(1) << S_WRITE,
        ST_MMU    = NSTATES'(1) << S_MMU,
        ST_FETCH  = NSTATES'(1) << S_FETCH,
        ST_HALT   = NSTATES'(1) << S_HALT
    } seq_state_e;

endpackage

// File: rtl/cpu_state_seq_if.sv
// Control/status bundle between the microcycle sequencer and its environment.
// The master drives the hold/halt/step controls; the slave returns phase strobes.
interface cpu_state_seq_if #(parameter int CNT_W = 32);

    logic             halt_req;
    logic             step;
    logic             mmu_wait;
    logic             fetch_wait;
    logic             state_decode;
    logic             state_read;
    logic             state_alu;
    logic             state_write;
    logic             state_mmu;
    logic             state_fetch;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output halt_req, step, mmu_wait, fetch_wait,
        input  state_decode, state_read, state_alu, state_write,
        input  state_mmu, state_fetch, halted, cycle_count
    );

    modport slave (
        input  halt_req, step, mmu_wait, fetch_wait,
        output state_decode, state_read, state_alu, state_write,
        output state_mmu, state_fetch, halted, cycle_count
    );

endinterface

// File: rtl/cpu_state_seq_cycle_counter.sv
// Wrapping counter of retired microinstructions with synchronous clear.
module cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_state_seq.sv
// CADR4 microcycle sequencer: one-hot DECODE..FETCH phases with memory waits,
// halt/single-step control and a retired-instruction counter.
module cpu_state_seq
    import cadr_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    cpu_state_seq_if.slave  bus
);

    seq_state_e       state_q;
    logic             one_shot_q;
    logic             fetch_exit;
    logic [CNT_W-1:0] count;

    assign fetch_exit = (state_q == ST_FETCH) && !bus.fetch_wait;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_DECODE;
            one_shot_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_DECODE: state_q <= ST_READ;
                ST_READ:   state_q <= ST_ALU;
                ST_ALU:    state_q <= ST_WRITE;
                ST_WRITE:  state_q <= ST_MMU;
                ST_MMU: begin
                    if (!bus.mmu_wait) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // A stepped instruction always lands back in HALT.
                    if (!bus.fetch_wait) begin
                        state_q    <= (bus.halt_req || one_shot_q) ? ST_HALT : ST_DECODE;
                        one_shot_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (!bus.halt_req) begin
                        state_q    <= ST_DECODE;
                        one_shot_q <= 1'b0;
                    end else if (bus.step) begin
                        state_q    <= ST_DECODE;
                        one_shot_q <= 1'b1;
                    end
                end
                default: begin
                    // Corrupted encoding: restart cleanly at an instruction boundary.
                    state_q    <= ST_DECODE;
                    one_shot_q <= 1'b0;
                end
            endcase
        end
    end

    cycle_counter #(.CNT_W(CNT_W)) u_cycle_counter (
        .clk     (clk),
        .clr_i   (reset),
        .en_i    (fetch_exit),
        .count_o (count)
    );

    assign bus.state_decode = state_q[S_DECODE];
    assign bus.state_read   = state_q[S_READ];
    assign bus.state_alu    = state_q[S_ALU];
    assign bus.state_write  = state_q[S_WRITE];
    assign bus.state_mmu    = state_q[S_MMU];
    assign bus.state_fetch  = state_q[S_FETCH];
    assign bus.halted       = state_q[S_HALT];
    assign bus.cycle_count  = count;

endmodule

// File: tb/tb_cpu_state_seq.sv
// Directed bench for cpu_state_seq: a 32-bit and a 4-bit counter instance driven
// in lockstep from a table of {inputs, expected phase, expected count} records.
module tb_cpu_state_seq;

    localparam logic [6:0] D = 7'h01;
    localparam logic [6:0] R = 7'h02;
    localparam logic [6:0] A = 7'h04;
    localparam logic [6:0] W = 7'h08;
    localparam logic [6:0] M = 7'h10;
    localparam logic [6:0] F = 7'h20;
    localparam logic [6:0] H = 7'h40;

    typedef struct {
        logic        rst;
        logic        hr;
        logic        st;
        logic        mw;
        logic        fw;
        logic [6:0]  exp_state;
        int unsigned exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic halt_req;
    logic step;
    logic mmu_wait;
    logic fetch_wait;

    int n_cmp = 0;
    int n_bad = 0;
    int vidx  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cpu_state_seq_if #(.CNT_W(32)) bus32 ();
    cpu_state_seq_if #(.CNT_W(4))  bus4 ();

    assign bus32.halt_req   = halt_req;
    assign bus32.step       = step;
    assign bus32.mmu_wait   = mmu_wait;
    assign bus32.fetch_wait = fetch_wait;
    assign bus4.halt_req    = halt_req;
    assign bus4.step        = step;
    assign bus4.mmu_wait    = mmu_wait;
    assign bus4.fetch_wait  = fetch_wait;

    cpu_state_seq #(.CNT_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    cpu_state_seq #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

    function automatic logic [6:0] obs32();
        return {bus32.halted, bus32.state_fetch, bus32.state_mmu, bus32.state_write,
                bus32.state_alu, bus32.state_read, bus32.state_decode};
    endfunction

    function automatic logic [6:0] obs4();
        return {bus4.halted, bus4.state_fetch, bus4.state_mmu, bus4.state_write,
                bus4.state_alu, bus4.state_read, bus4.state_decode};
    endfunction

    function automatic void add(logic rst, logic hr, logic st, logic mw, logic fw,
                                logic [6:0] es, int unsigned ec);
        vec_t v;
        v.rst = rst; v.hr = hr; v.st = st; v.mw = mw; v.fw = fw;
        v.exp_state = es; v.exp_cnt = ec;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(string tag, logic [6:0] es, int unsigned ec);
        check({tag, " state32"}, 32'(obs32()), 32'(es));
        check({tag, " state4"},  32'(obs4()),  32'(es));
        check({tag, " count32"}, bus32.cycle_count, ec);
        check({tag, " count4"},  32'(bus4.cycle_count), ec % 16);
    endtask

    task automatic run_until(int stop);
        vec_t v;
        while (vidx < stop) begin
            v = vecs[vidx];
            reset = v.rst; halt_req = v.hr; step = v.st; mmu_wait = v.mw; fetch_wait = v.fw;
            tick();
            $display("vec %0d: rst=%b hr=%b st=%b mw=%b fw=%b -> state=%07b cnt=%0d (want %07b %0d)",
                     vidx, v.rst, v.hr, v.st, v.mw, v.fw, obs32(), bus32.cycle_count,
                     v.exp_state, v.exp_cnt);
            check_all($sformatf("vec%0d", vidx), v.exp_state, v.exp_cnt);
            vidx++;
        end
    endtask

    initial begin
        int mk_halt;
        int mk_end;

        // Wait-state instruction: 3 MMU holds + 2 FETCH holds = 11 clocks; stray step/waits ignored.
        add(0,0,1,1,1, R,10);
        add(0,0,1,0,0, A,10);
        add(0,0,0,1,0, W,10);
        for (int i = 0; i < 4; i++) add(0,0,0,1,0, M,10);
        for (int i = 0; i < 3; i++) add(0,0,0,0,1, F,10);
        add(0,0,0,0,0, D,11);
        // halt_req raised in ALU: instruction completes, then HALT.
        add(0,0,0,0,0, R,11);
        add(0,0,0,0,0, A,11);
        add(0,1,0,0,0, W,11);
        add(0,1,0,0,0, M,11);
        add(0,1,0,0,0, F,11);
        add(0,1,0,0,0, H,12);
        mk_halt = vecs.size();
        // First step; a step pulse inside the excursion is ignored.
        add(0,1,1,0,0, D,12);
        add(0,1,0,0,0, R,12);
        add(0,1,1,0,0, A,12);
        add(0,1,0,0,0, W,12);
        add(0,1,0,0,0, M,12);
        add(0,1,0,0,0, F,12);
        add(0,1,0,0,0, H,13);
        for (int i = 0; i < 8; i++) add(0,1,0,0,0, H,13);
        // Second step, 15 clocks after the first.
        add(0,1,1,0,0, D,13);
        add(0,1,0,0,0, R,13);
        add(0,1,0,0,0, A,13);
        add(0,1,0,0,0, W,13);
        add(0,1,0,0,0, M,13);
        add(0,1,0,0,0, F,13);
        add(0,1,0,0,0, H,14);
        add(0,1,0,0,0, H,14);
        // Third step with halt_req dropped mid-instruction: still returns to HALT.
        add(0,1,1,0,0, D,14);
        add(0,1,0,0,0, R,14);
        add(0,0,0,0,0, A,14);
        add(0,0,0,0,0, W,14);
        add(0,0,0,0,0, M,14);
        add(0,0,0,0,0, F,14);
        add(0,0,0,0,0, H,15);
        // step with halt_req low: plain resume, so the next FETCH goes to DECODE.
        add(0,0,1,0,0, D,15);
        add(0,0,0,0,0, R,15);
        add(0,0,0,0,0, A,15);
        add(0,0,0,0,0, W,15);
        add(0,0,0,0,0, M,15);
        add(0,0,0,0,0, F,15);
        add(0,0,0,0,0, D,16);
        add(0,0,0,0,0, R,16);
        add(0,0,0,0,0, A,16);
        add(0,0,0,0,0, W,16);
        add(0,0,0,0,0, M,16);
        add(0,0,0,0,0, F,16);
        add(0,0,0,0,0, D,17);
        // Reset in WRITE, during an MMU hold, and in HALT.
        add(0,0,0,0,0, R,17);
        add(0,0,0,0,0, A,17);
        add(0,0,0,0,0, W,17);
        add(1,0,0,0,0, D,0);
        add(0,0,0,0,0, R,0);
        add(0,0,0,0,0, A,0);
        add(0,0,0,0,0, W,0);
        add(0,0,0,1,0, M,0);
        add(0,0,0,1,0, M,0);
        add(1,0,0,1,0, D,0);
        add(0,0,0,0,0, R,0);
        add(0,0,0,0,0, A,0);
        add(0,0,0,0,0, W,0);
        add(0,1,0,0,0, M,0);
        add(0,1,0,0,0, F,0);
        add(0,1,0,0,0, H,1);
        add(1,1,0,0,0, D,0);
        add(0,0,0,0,0, R,0);
        mk_end = vecs.size();

        reset = 1'b1; halt_req = 1'b0; step = 1'b0; mmu_wait = 1'b0; fetch_wait = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        $display("reset: state=%07b cnt=%0d halted=%b", obs32(), bus32.cycle_count, bus32.halted);
        check_all("reset", D, 0);

        // Free run: period-6 rotation, one retirement per FETCH exit.
        for (int k = 1; k <= 60; k++) begin
            logic [6:0] es;
            es = 7'h01 << (k % 6);
            tick();
            $display("run %0d: state=%07b cnt=%0d", k, obs32(), bus32.cycle_count);
            check_all($sformatf("run%0d", k), es, k / 6);
        end

        run_until(mk_halt);

        // Held in HALT: strobes off, counter frozen.
        for (int k = 0; k < 20; k++) begin
            halt_req = 1'b1; step = 1'b0;
            tick();
            $display("hold %0d: state=%07b cnt=%0d", k, obs32(), bus32.cycle_count);
            check_all($sformatf("hold%0d", k), H, 12);
        end

        run_until(mk_end);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_state_seq.md
# cpu_state_seq

Microcycle state sequencer for the CADR4 processor. It steps the machine through the six one-hot phases of each microinstruction: DECODE, READ, ALU, WRITE, MMU, FETCH. The phase strobes it produces feed the bus-drive logic, which enables the MF drive during ALU, WRITE, MMU or FETCH. It also provides memory-wait holds, halt/single-step control and a retired-cycle counter.

## Interface
- CNT_W, 32: width of the retired-microinstruction counter.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- halt_req  in  1  level; stop at the next instruction boundary and stay halted while high.
- step  in  1  one-cycle pulse; sampled only while halted; runs exactly one microinstruction.
- mmu_wait  in  1  level; holds the sequencer in MMU.
- fetch_wait  in  1  level; holds the sequencer in FETCH.
- state_decode, state_read, state_alu, state_write, state_mmu, state_fetch  out  1 each  registered one-hot phase strobes.
- halted  out  1  registered; high while in HALT.
- cycle_count  out  CNT_W  number of microinstructions retired.

## Operation
- States: DECODE, READ, ALU, WRITE, MMU, FETCH, HALT. The register is one-hot, 7 bits.
- Each state_* output equals its state bit. In HALT all six strobes are 0 and halted=1.
- Transitions:
  - DECODE→READ→ALU→WRITE→MMU unconditionally.
  - MMU: stay while mmu_wait, else go to FETCH.
  - FETCH: stay while fetch_wait. Otherwise go to HALT if (halt_req & ~one_shot) or one_shot; else go to DECODE.
  - HALT: if ~halt_req, go to DECODE (resume; one_shot cleared). Else if step, go to DECODE with one_shot set. Else stay.
- one_shot is an internal flag. It is set on the step exit from HALT and cleared on the next FETCH exit.
  - A stepped instruction always returns to HALT, even if halt_req dropped meanwhile.
- step outside HALT is ignored and not remembered.
- halt_req is sampled only in FETCH (on exit) and in HALT. Asserting it mid-instruction never truncates the instruction.
- cycle_count increments by 1, modulo 2^CNT_W, on every FETCH exit (fetch_wait=0). It never increments in HALT and wraps from all-ones to 0.
- mmu_wait and fetch_wait are ignored outside their own states.
- Invariant: exactly one state bit is set at all times. An illegal encoding (e.g. from SEU) recovers to DECODE on the next edge, with one_shot cleared.

## Timing
- Reset, synchronous: on the edge where reset=1, the next state is DECODE.
  - Outputs: state_decode=1, other strobes 0, halted=0, cycle_count=0, one_shot=0.
  - reset overrides everything, including mid-wait and HALT.
- The first DECODE strobe is visible in the cycle after reset is sampled high. The machine runs immediately unless halt_req is high at the first FETCH.
- A no-wait instruction takes 6 clocks.
  - Each mmu_wait or fetch_wait cycle adds one clock.
  - Entering or leaving HALT costs one extra clock: FETCH→HALT→DECODE.
- All outputs are registered, with no combinational path from inputs to outputs. An input sampled at edge N affects the outputs after edge N.
- cycle_count updates on the same edge that leaves FETCH.
- halt_req and step together in HALT: step wins only while halt_req=1. If halt_req=0, resume takes priority and one_shot stays clear.

## Structure
- A shared package/include cadr_seq_pkg holds the one-hot state index constants (S_DECODE..S_HALT, 7 bits) and the NSTATES constant. MF and other phase consumers use the same names.
- One natural sub-module is cycle_counter, a CNT_W wrapping counter with a synchronous clear and an increment enable. The rest is a single next-state always block plus the output register.

## Test plan
- Reset, then free run with all inputs 0 → strobes cycle DECODE..FETCH with period 6. After 10 instructions (60 clocks after reset) cycle_count=10 and halted=0.
- mmu_wait high for 3 cycles on entry to MMU, and fetch_wait high for 2 cycles in FETCH → instruction takes 11 clocks and cycle_count increments once, on the FETCH exit.
- Assert halt_req during ALU → the instruction completes, then HALT. halted=1 and all strobes 0. cycle_count is held for 20 clocks.
- While halted with halt_req=1, pulse step twice, 15 clocks apart → two 7-clock excursions (DECODE..FETCH, then HALT). cycle_count increases by exactly 2.
  - A step pulse during the excursion is ignored.
- During a stepped instruction drop halt_req → the sequencer still returns to HALT, then resumes on the next clock, since halt_req=0.
- Preload CNT_W=4 and run 17 instructions → cycle_count wraps 15→0→1. Assert reset in WRITE → next cycle state_decode=1, cycle_count=0, halted=0.
